sum_frame_accum: RTL and testbench

SUM_FRAME_ACCUM -- requirements
Module: sum_frame_accum

---
 rtl/sum_frame_accum.sv | 121 ++++++++++++
 tb/tb_sum_frame_accum.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_frame_accum.sv
// Frame accumulator: sums unsigned samples into saturating frames of FRAME_LEN
// (or shorter on flush) and holds each result until the consumer takes it.
module sum_frame_accum #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SWIDTH    = WIDTH + 1,
  parameter int unsigned ACCW      = 40,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned CNTW      = $clog2(FRAME_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SWIDTH-1:0] in_sum,
  input  logic              in_zero,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACCW-1:0]   out_acc,
  output logic [CNTW-1:0]   out_len,
  output logic [CNTW-1:0]   out_zero_cnt,
  output logic              out_sat
);

  if (ACCW < SWIDTH || FRAME_LEN < 1 || SWIDTH < WIDTH) begin : g_bad_param
    $error("sum_frame_accum: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_HOLD
  } state_t;

  localparam logic [ACCW-1:0] ACC_MAX = '1;
  localparam logic [CNTW-1:0] LEN_END = CNTW'(FRAME_LEN);

  state_t          state, state_nxt;
  logic [ACCW-1:0] acc, acc_nxt;
  logic [CNTW-1:0] len, len_nxt;
  logic [CNTW-1:0] zcnt, zcnt_nxt;
  logic            sat, sat_nxt;

  logic            accept;
  logic [ACCW:0]   sum_ext;
  logic [ACCW:0]   add_res;
  logic [CNTW-1:0] len_inc;

  assign in_ready  = (state != S_HOLD);
  assign out_valid = (state == S_HOLD);
  assign accept    = in_valid && in_ready;

  always_comb begin
    sum_ext               = '0;
    sum_ext[SWIDTH-1:0]   = in_sum;
  end

  // One spare carry bit on the adder makes overflow detection a single bit test.
  assign add_res = {1'b0, acc} + sum_ext;
  assign len_inc = len + CNTW'(1);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    len_nxt   = len;
    zcnt_nxt  = zcnt;
    sat_nxt   = sat;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          acc_nxt  = sum_ext[ACCW-1:0];
          len_nxt  = CNTW'(1);
          zcnt_nxt = CNTW'(in_zero);
          sat_nxt  = 1'b0;
          state_nxt = (FRAME_LEN == 1 || flush) ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          if (add_res[ACCW]) begin
            acc_nxt = ACC_MAX;
            sat_nxt = 1'b1;
          end else begin
            acc_nxt = add_res[ACCW-1:0];
          end
          len_nxt  = len_inc;
          zcnt_nxt = zcnt + CNTW'(in_zero);
          if (len_inc == LEN_END || flush) state_nxt = S_HOLD;
        end else if (flush) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      acc   <= '0;
      len   <= '0;
      zcnt  <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      len   <= len_nxt;
      zcnt  <= zcnt_nxt;
      sat   <= sat_nxt;
    end
  end

  assign out_acc      = acc;
  assign out_len      = len;
  assign out_zero_cnt = zcnt;
  assign out_sat      = sat;

endmodule

// File: tb/tb_sum_frame_accum.sv
// Bench for sum_frame_accum: two instances (ACCW=40 and ACCW=34) on shared
// stimulus, checked by directed tables/sequences and a frame-level reference model.
module tb_sum_frame_accum;

  localparam int unsigned FL = 4;
  localparam int unsigned SW = 33;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_zero = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [SW-1:0] in_sum = '0;

  logic          in_ready_a, out_valid_a, out_sat_a;
  logic [39:0]   out_acc_a;
  logic [CW-1:0] out_len_a, out_zc_a;
  logic          in_ready_b, out_valid_b, out_sat_b;
  logic [33:0]   out_acc_b;
  logic [CW-1:0] out_len_b, out_zc_b;

  sum_frame_accum #(.WIDTH(32), .ACCW(40), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_sum(in_sum), .in_zero(in_zero), .flush(flush),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_acc(out_acc_a),
    .out_len(out_len_a), .out_zero_cnt(out_zc_a), .out_sat(out_sat_a)
  );

  sum_frame_accum #(.WIDTH(32), .ACCW(34), .FRAME_LEN(FL)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_sum(in_sum), .in_zero(in_zero), .flush(flush),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_acc(out_acc_b),
    .out_len(out_len_b), .out_zero_cnt(out_zc_b), .out_sat(out_sat_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a frame is just the list of accepted samples; the result
  // is their total clamped to the accumulator range.
  bit                m_hold = 1'b0;
  longint unsigned   q_sum[$];
  bit                q_z[$];
  longint unsigned   r_total;
  int                r_len, r_zc;

  function automatic longint unsigned acc_max(int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint unsigned clamp(longint unsigned t, int w);
    return (t > acc_max(w)) ? acc_max(w) : t;
  endfunction

  task automatic model_reset();
    m_hold = 1'b0;
    q_sum.delete();
    q_z.delete();
  endtask

  task automatic model_edge(bit v, longint unsigned s, bit z, bit f, bit r);
    if (m_hold) begin
      if (r) model_reset();
    end else begin
      if (v) begin
        q_sum.push_back(s);
        q_z.push_back(z);
      end
      if (q_sum.size() == FL || (f && q_sum.size() > 0)) begin
        r_total = 0;
        r_zc    = 0;
        foreach (q_sum[i]) begin
          r_total += q_sum[i];
          r_zc    += int'(q_z[i]);
        end
        r_len  = q_sum.size();
        m_hold = 1'b1;
      end
    end
  endtask

  task automatic model_check();
    chk("model_in_ready_a", in_ready_a, !m_hold);
    chk("model_in_ready_b", in_ready_b, !m_hold);
    chk("model_out_valid_a", out_valid_a, m_hold);
    chk("model_out_valid_b", out_valid_b, m_hold);
    if (m_hold) begin
      chk("model_acc_a", out_acc_a, clamp(r_total, 40));
      chk("model_sat_a", out_sat_a, r_total > acc_max(40));
      chk("model_len_a", out_len_a, r_len);
      chk("model_zc_a", out_zc_a, r_zc);
      chk("model_acc_b", out_acc_b, clamp(r_total, 34));
      chk("model_sat_b", out_sat_b, r_total > acc_max(34));
      chk("model_len_b", out_len_b, r_len);
      chk("model_zc_b", out_zc_b, r_zc);
    end
  endtask

  task automatic cycle(bit v, longint unsigned s, bit z, bit f, bit r);
    in_valid  = v;
    in_sum    = SW'(s);
    in_zero   = z;
    flush     = f;
    out_ready = r;
    model_edge(v, s, z, f, r);
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_in_ready"}, in_ready_a, 1);
    chk({tag, "_out_valid"}, out_valid_a, 0);
    chk({tag, "_acc"}, out_acc_a, 0);
    chk({tag, "_len"}, out_len_a, 0);
    chk({tag, "_zc"}, out_zc_a, 0);
    chk({tag, "_sat"}, out_sat_a, 0);
    chk({tag, "_in_ready_b"}, in_ready_b, 1);
    chk({tag, "_acc_b"}, out_acc_b, 0);
  endtask

  // Raises rst between edges and checks the asynchronous effect before any edge.
  task automatic pulse_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    bit              v;
    longint unsigned s;
    bit              z;
    bit              f;
    bit              r;
    bit              e_valid;
    longint unsigned e_acc;
    int              e_len;
    int              e_zc;
    bit              e_sat;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1, 1, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 2, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 3, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[3] = '{1, 0, 1, 0, 1, 1, 6, 4, 1, 0};
    tbl[4] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[5] = '{1, 5, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[6] = '{1, 7, 0, 1, 1, 1, 12, 2, 0, 0};
    tbl[7] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[8] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    tbl[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};

    #3 check_reset_outputs("por");
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic frame, single-cycle pulse, flush frame, flush alone in IDLE.
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].v, tbl[i].s, tbl[i].z, tbl[i].f, tbl[i].r);
      chk($sformatf("tbl%0d_valid", i), out_valid_a, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_acc", i), out_acc_a, tbl[i].e_acc);
        chk($sformatf("tbl%0d_len", i), out_len_a, tbl[i].e_len);
        chk($sformatf("tbl%0d_zc", i), out_zc_a, tbl[i].e_zc);
        chk($sformatf("tbl%0d_sat", i), out_sat_a, tbl[i].e_sat);
      end
    end

    // Saturation on the 34-bit instance; the 40-bit one does not saturate.
    for (int i = 0; i < 4; i++) cycle(1, 64'h1_FFFF_FFFF, 0, 0, 0);
    chk("sat_valid_b", out_valid_b, 1);
    chk("sat_acc_b", out_acc_b, 64'h3_FFFF_FFFF);
    chk("sat_flag_b", out_sat_b, 1);
    chk("sat_acc_a", out_acc_a, 64'h7_FFFF_FFFC);
    chk("sat_flag_a", out_sat_a, 0);
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0);
    chk("unsat_acc_b", out_acc_b, 4);
    chk("unsat_flag_b", out_sat_b, 0);

    // Backpressure: frame of four 1s held while the source keeps offering.
    for (int i = 0; i < 5; i++) begin
      cycle(1, 64'(i + 100), 1, 1, 0);
      chk("bp_in_ready", in_ready_a, 0);
      chk("bp_acc", out_acc_a, 4);
      chk("bp_len", out_len_a, 4);
      chk("bp_zc", out_zc_a, 0);
    end
    cycle(0, 0, 0, 0, 1);
    chk("bp_release_ready", in_ready_a, 1);
    chk("bp_release_valid", out_valid_a, 0);
    for (int i = 0; i < 4; i++) cycle(1, 2, 0, 0, 1);
    chk("bp_next_acc", out_acc_a, 8);
    chk("bp_next_len", out_len_a, 4);
    chk("bp_next_sat", out_sat_a, 0);
    cycle(0, 0, 0, 0, 1);

    // Reset mid-frame discards the partial frame.
    cycle(1, 9, 1, 0, 1);
    cycle(1, 9, 1, 0, 1);
    pulse_reset();
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 1);
    chk("rst_mid_acc", out_acc_a, 4);
    chk("rst_mid_len", out_len_a, 4);
    chk("rst_mid_zc", out_zc_a, 0);
    cycle(0, 0, 0, 0, 1);

    // Reset while a result is held: no pulse afterwards.
    for (int i = 0; i < 4; i++) cycle(1, 3, 0, 0, 0);
    pulse_reset();
    cycle(0, 0, 0, 0, 1);
    chk("rst_hold_valid", out_valid_a, 0);

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      longint unsigned s;
      s = {$urandom, $urandom} & acc_max(SW);
      if ($urandom_range(3) == 0) s = acc_max(SW);
      cycle($urandom_range(3) != 0, s, $urandom_range(1) == 1,
            $urandom_range(7) == 0, $urandom_range(2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
